// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer for a conditional ADD/ADI/NAND instruction subset.
// It drives an external register file and combinational ALU, and owns the carry and zero flags.
module alu_seq_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IMM_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      instr,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       rf_raddr_a,
  output logic [2:0]       rf_raddr_b,
  input  logic [WIDTH-1:0] rf_rdata_a,
  input  logic [WIDTH-1:0] rf_rdata_b,
  output logic             rf_we,
  output logic [2:0]       rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic             alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic             carry_flag,
  output logic             zero_flag
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_ADI = 4'h1;
  localparam logic [3:0] OP_NDU = 4'h2;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [15:0]      r_instr;
  logic             r_exec;
  logic             r_cout;

  logic [3:0]       w_opcode;
  logic [1:0]       w_cz;
  logic             w_is_add;
  logic             w_is_adi;
  logic             w_is_nd;
  logic             w_legal;
  logic             w_cond;
  logic [WIDTH-1:0] w_imm_ext;
  logic             w_unused;

  // Decode of the latched instruction; ADI has no cz field and always executes
  assign w_opcode  = r_instr[15:12];
  assign w_cz      = r_instr[1:0];
  assign w_is_add  = (w_opcode == OP_ADD) && (w_cz != 2'b11);
  assign w_is_adi  = (w_opcode == OP_ADI);
  assign w_is_nd   = (w_opcode == OP_NDU) && (w_cz != 2'b11);
  assign w_legal   = w_is_add || w_is_adi || w_is_nd;
  assign w_cond    = w_is_adi || (w_cz == 2'b00) ||
                     ((w_cz == 2'b10) && carry_flag) ||
                     ((w_cz == 2'b01) && zero_flag);
  assign w_imm_ext = {{(WIDTH-IMM_W){r_instr[IMM_W-1]}}, r_instr[IMM_W-1:0]};
  assign w_unused  = ^{r_instr[11:9], r_instr[2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_READ;
      S_READ:  w_next = w_legal ? S_EXEC : S_IDLE;
      S_EXEC:  w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Registered datapath/handshake outputs; per-state drives fall back to 0 each cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr    <= '0;
      r_exec     <= 1'b0;
      r_cout     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      rf_raddr_a <= '0;
      rf_raddr_b <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_op     <= 1'b0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else begin
      busy       <= (w_next != S_IDLE);
      done       <= 1'b0;
      err        <= 1'b0;
      rf_raddr_a <= '0;
      rf_raddr_b <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_op     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_instr    <= instr;
            rf_raddr_a <= instr[11:9];
            rf_raddr_b <= instr[8:6];
          end
        end
        S_READ: begin
          if (w_legal) begin
            alu_in1 <= rf_rdata_a;
            alu_in2 <= w_is_adi ? w_imm_ext : rf_rdata_b;
            alu_op  <= w_is_nd;
          end else begin
            done <= 1'b1;
            err  <= 1'b1;
          end
        end
        S_EXEC: begin
          r_exec <= w_cond;
          r_cout <= alu_cout;
          if (w_cond) begin
            rf_we    <= 1'b1;
            rf_waddr <= w_is_adi ? r_instr[8:6] : r_instr[5:3];
            rf_wdata <= alu_result;
          end
        end
        S_WB: begin
          done <= 1'b1;
          if (r_exec) begin
            zero_flag <= (rf_wdata == '0);
            if (!w_is_nd) carry_flag <= r_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: models the register file and ALU around the sequencer
// and predicts writes, flags, error and latency for every issued instruction.
module tb_alu_seq_ctrl;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [15:0]  instr;
  logic         busy, done, err;
  logic [2:0]   rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [W-1:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic         rf_we;
  logic [W-1:0] alu_in1, alu_in2, alu_result;
  logic         alu_op, alu_cout;
  logic         carry_flag, zero_flag;

  alu_seq_ctrl #(.WIDTH(W), .IMM_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
    .busy(busy), .done(done), .err(err),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .carry_flag(carry_flag), .zero_flag(zero_flag)
  );

  always #5 clk = ~clk;

  // Environment: register file (with a preload port) and combinational ALU
  logic [W-1:0] rf [8];
  logic         pl_we;
  logic [2:0]   pl_a;
  logic [W-1:0] pl_d;

  always @(posedge clk) begin
    if (rf_we)      rf[rf_waddr] <= rf_wdata;
    else if (pl_we) rf[pl_a]     <= pl_d;
  end

  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];

  always_comb begin
    if (alu_op) {alu_cout, alu_result} = {1'b0, ~(alu_in1 & alu_in2)};
    else        {alu_cout, alu_result} = {1'b0, alu_in1} + {1'b0, alu_in2};
  end

  typedef struct {
    logic         err;
    logic         we;
    logic [2:0]   waddr;
    logic [W-1:0] wdata;
    logic         c;
    logic         z;
    int           lat;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         op;
  } exp_t;

  exp_t         sbq[$];
  logic [W-1:0] m_rf [8];
  logic         m_c, m_z;
  int           n_chk = 0;
  int           n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pl(input logic [2:0] a, input logic [W-1:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_we = 1'b0;
    m_rf[a] = d;
  endtask

  // Reference model: computes the outcome of one instruction and pushes it
  task automatic predict(input logic [15:0] ins);
    exp_t       e;
    logic [3:0] op;
    logic [1:0] cz;
    logic       legal, cond;
    logic [W:0] sum;
    logic [W-1:0] r;
    op = ins[15:12];
    cz = ins[1:0];
    legal = (op == 4'h1) || (((op == 4'h0) || (op == 4'h2)) && (cz != 2'b11));
    e.err = !legal; e.we = 1'b0; e.waddr = '0; e.wdata = '0;
    e.in1 = '0; e.in2 = '0; e.op = 1'b0;
    e.lat = legal ? 4 : 2;
    if (legal) begin
      e.in1 = m_rf[ins[11:9]];
      e.in2 = (op == 4'h1) ? {{10{ins[5]}}, ins[5:0]} : m_rf[ins[8:6]];
      e.op  = (op == 4'h2);
      cond  = (op == 4'h1) || (cz == 2'b00) || ((cz == 2'b10) && m_c) || ((cz == 2'b01) && m_z);
      sum   = {1'b0, e.in1} + {1'b0, e.in2};
      r     = e.op ? ~(e.in1 & e.in2) : sum[W-1:0];
      if (cond) begin
        e.we    = 1'b1;
        e.waddr = (op == 4'h1) ? ins[8:6] : ins[5:3];
        e.wdata = r;
        m_rf[e.waddr] = r;
        if (!e.op) m_c = sum[W];
        m_z = (r == '0);
      end
    end
    e.c = m_c; e.z = m_z;
    sbq.push_back(e);
  endtask

  // Issue one instruction; 'now' drives start on the current negedge, 'poke' retries start while busy
  task automatic run_instr(input logic [15:0] ins, input bit now, input bit poke);
    exp_t       e, pk;
    int         done_k, we_n;
    logic [2:0] wa;
    logic [W-1:0] wd;
    logic       errv;
    predict(ins);
    pk = sbq[0];
    if (!now) @(negedge clk);
    start = 1'b1; instr = ins;
    @(posedge clk);
    done_k = 0; we_n = 0; wa = '0; wd = '0; errv = 1'b0;
    for (int k = 1; k <= 10 && done_k == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = poke;
        instr = {4'h0, 3'd1, 3'd1, 3'd7, 3'b000};
        chk("busy_read", busy, 1'b1);
        chk("alu_in1_read", alu_in1, '0);
      end
      if (k == 2) begin
        start = 1'b0;
        if (pk.lat == 4) begin
          chk("alu_in1", alu_in1, pk.in1);
          chk("alu_in2", alu_in2, pk.in2);
          chk("alu_op", alu_op, pk.op);
        end
      end
      if (rf_we) begin we_n++; wa = rf_waddr; wd = rf_wdata; end
      if (done) begin done_k = k; errv = err; end
    end
    if (done_k == 0) chk("done_timeout", 0, 1);
    e = sbq.pop_front();
    chk("latency", 32'(done_k), 32'(e.lat));
    chk("err", errv, e.err);
    chk("we_count", 32'(we_n), 32'(e.we));
    if (e.we) begin
      chk("waddr", wa, e.waddr);
      chk("wdata", wd, e.wdata);
      chk("rf_written", rf[e.waddr], e.wdata);
    end
    chk("carry", carry_flag, e.c);
    chk("zero", zero_flag, e.z);
    chk("busy_done", busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; instr = '0;
    pl_we = 1'b0; pl_a = '0; pl_d = '0;
    m_c = 1'b0; m_z = 1'b0;
    for (int i = 0; i < 8; i++) pl(3'(i), '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_we", rf_we, 1'b0);
    chk("rst_flags", {carry_flag, zero_flag}, 2'b00);
    chk("rst_alu", {alu_in1, alu_in2, alu_op}, '0);
    chk("rst_wport", {rf_waddr, rf_wdata}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    pl(3'd1, 16'hFFFF); pl(3'd2, 16'h0001); pl(3'd5, 16'h0010);
    run_instr({4'h0, 3'd1, 3'd2, 3'd3, 3'b000}, 1'b0, 1'b0);      // ADD
    chk("add_r3", rf[3], 16'h0000);
    chk("add_flags", {carry_flag, zero_flag}, 2'b11);
    run_instr({4'h0, 3'd2, 3'd2, 3'd7, 3'b000}, 1'b0, 1'b0);      // ADD -> c0 z0
    run_instr({4'h0, 3'd1, 3'd2, 3'd4, 3'b010}, 1'b0, 1'b0);      // ADC skipped
    chk("adc_skip_r4", rf[4], 16'h0000);
    run_instr({4'h0, 3'd1, 3'd2, 3'd3, 3'b000}, 1'b0, 1'b0);      // ADD -> c1 z1
    pl(3'd1, 16'hFF00); pl(3'd2, 16'h0F0F);
    run_instr({4'h2, 3'd1, 3'd2, 3'd3, 3'b001}, 1'b0, 1'b0);      // NDZ
    chk("ndz_r3", rf[3], 16'hF0FF);
    chk("ndz_flags", {carry_flag, zero_flag}, 2'b10);
    run_instr({4'h2, 3'd3, 3'd2, 3'd4, 3'b010}, 1'b1, 1'b0);      // NDC back-to-back
    run_instr({4'h1, 3'd5, 3'd6, 6'b111110}, 1'b0, 1'b0);         // ADI -2
    chk("adi_r6", rf[6], 16'h000E);
    chk("adi_flags", {carry_flag, zero_flag}, 2'b10);
    run_instr(16'hF000, 1'b0, 1'b1);                              // illegal opcode, start while busy
    run_instr({4'h0, 3'd1, 3'd2, 3'd3, 3'b011}, 1'b1, 1'b0);      // ADD cz=11 illegal
    run_instr({4'h2, 3'd1, 3'd2, 3'd5, 3'b001}, 1'b0, 1'b0);      // NDZ skipped
    run_instr({4'h2, 3'd0, 3'd0, 3'd1, 3'b000}, 1'b0, 1'b1);      // NDU -> R1=FFFF
    run_instr({4'h1, 3'd1, 3'd2, 6'b000101}, 1'b0, 1'b0);         // ADI wrap FFFF+5
    chk("adi_wrap_r2", rf[2], 16'h0004);

    // Reset in EXEC aborts the operation
    @(negedge clk);
    start = 1'b1; instr = {4'h0, 3'd1, 3'd2, 3'd5, 3'b000};
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_c = 1'b0; m_z = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_flags", {carry_flag, zero_flag}, 2'b00);
    chk("abort_we", rf_we, 1'b0);
    chk("abort_alu", alu_in1, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_quiet", {done, rf_we, busy}, 3'b000);
    end
    run_instr({4'h0, 3'd1, 3'd2, 3'd5, 3'b000}, 1'b0, 1'b0);      // ADD after reset
    chk("post_rst_r5", rf[5], 16'h0003);

    for (int i = 0; i < 8; i++) chk($sformatf("rf_final%0d", i), rf[i], m_rf[i]);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
